branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 145 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : Resolves conditional/unconditional branches one cycle after accept
//            and holds the front end in a fixed-length flush after taken ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
  parameter int PC_W         = 32,
  parameter int OFF_W        = 26,
  parameter int FLUSH_CYCLES = 2,
  parameter int FLAG_BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready,
  input  logic [2:0]        jtype,
  input  logic              link,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [OFF_W-1:0]  offset,
  input  logic [PC_W-1:0]   reg_target,
  input  logic              flag_we,
  input  logic              sign_in,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic              taken,
  output logic [PC_W-1:0]   next_pc,
  output logic              pc_valid,
  output logic              link_we,
  output logic [PC_W-1:0]   link_addr,
  output logic              flush
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0]      C_FLUSH_CYCLES = 4'(FLUSH_CYCLES);
  localparam logic [PC_W-1:0] C_FOUR         = PC_W'(4);
  localparam logic [2:0]      C_J_NONE = 3'd0, C_J_B    = 3'd1, C_J_BR  = 3'd2,
                              C_J_BLTZ = 3'd3, C_J_BZ   = 3'd4, C_J_BNZ = 3'd5,
                              C_J_BCY  = 3'd6, C_J_BNCY = 3'd7;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_sf, r_cf, r_zf;
  logic              r_taken, r_pc_valid, r_link_we;
  logic [PC_W-1:0]   r_next_pc, r_link_addr;

  logic              w_accept, w_bypass, w_sf, w_cf, w_zf, w_taken;
  logic [PC_W-1:0]   w_seq_pc, w_off_ext, w_target;

  assign ready    = (r_state == IDLE);
  assign flush    = (r_state == FLUSH);
  assign w_accept = valid_in & ready;

  // Same-cycle flag forwarding lets a branch follow its flag-setting op directly.
  assign w_bypass = (FLAG_BYPASS != 0) && flag_we;
  assign w_sf     = w_bypass ? sign_in  : r_sf;
  assign w_cf     = w_bypass ? carry_in : r_cf;
  assign w_zf     = w_bypass ? zero_in  : r_zf;

  assign w_seq_pc  = pc_in + C_FOUR;
  assign w_off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign w_target  = (jtype == C_J_BR) ? reg_target : (w_seq_pc + (w_off_ext << 2));

  always_comb begin
    w_taken = 1'b0;
    case (jtype)
      C_J_NONE: w_taken = 1'b0;
      C_J_B:    w_taken = 1'b1;
      C_J_BR:   w_taken = 1'b1;
      C_J_BLTZ: w_taken = w_sf;
      C_J_BZ:   w_taken = w_zf;
      C_J_BNZ:  w_taken = ~w_zf;
      C_J_BCY:  w_taken = w_cf;
      C_J_BNCY: w_taken = ~w_cf;
      default:  w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_sf        <= 1'b0;
      r_cf        <= 1'b0;
      r_zf        <= 1'b0;
      r_taken     <= 1'b0;
      r_pc_valid  <= 1'b0;
      r_link_we   <= 1'b0;
      r_next_pc   <= '0;
      r_link_addr <= '0;
    end else begin
      if (flag_we) begin
        r_sf <= sign_in;
        r_cf <= carry_in;
        r_zf <= zero_in;
      end
      r_taken    <= 1'b0;
      r_pc_valid <= 1'b0;
      r_link_we  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pc_valid  <= 1'b1;
            r_taken     <= w_taken;
            r_link_we   <= w_taken & link;
            r_next_pc   <= w_taken ? w_target : w_seq_pc;
            r_link_addr <= w_seq_pc;
            if (w_taken && (C_FLUSH_CYCLES != 4'd0)) begin
              r_state <= FLUSH;
              r_cnt   <= C_FLUSH_CYCLES;
            end
          end
        end
        FLUSH: begin
          // Leaving when the count reaches 1 keeps flush high for exactly FLUSH_CYCLES.
          if (r_cnt <= 4'd1) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign taken     = r_taken;
  assign pc_valid  = r_pc_valid;
  assign link_we   = r_link_we;
  assign next_pc   = r_next_pc;
  assign link_addr = r_link_addr;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module   : tb_branch_resolve_unit
// Brief    : Directed bench for branch_resolve_unit (default, 16-bit PC and
//            zero-flush instances share one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [2:0]  jtype;
  logic        link;
  logic [31:0] pc_in;
  logic [25:0] offset;
  logic [31:0] reg_target;
  logic        flag_we, sign_in, carry_in, zero_in;

  logic        a_ready, a_taken, a_pc_valid, a_link_we, a_flush;
  logic [31:0] a_next_pc, a_link_addr;
  logic        b_ready, b_taken, b_pc_valid, b_link_we, b_flush;
  logic [15:0] b_next_pc, b_link_addr;
  logic        c_ready, c_taken, c_pc_valid, c_link_we, c_flush;
  logic [31:0] c_next_pc, c_link_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit u_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready(a_ready), .jtype(jtype),
    .link(link), .pc_in(pc_in), .offset(offset), .reg_target(reg_target),
    .flag_we(flag_we), .sign_in(sign_in), .carry_in(carry_in), .zero_in(zero_in),
    .taken(a_taken), .next_pc(a_next_pc), .pc_valid(a_pc_valid),
    .link_we(a_link_we), .link_addr(a_link_addr), .flush(a_flush)
  );

  branch_resolve_unit #(.PC_W(16), .OFF_W(14)) u_b (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready(b_ready), .jtype(jtype),
    .link(link), .pc_in(pc_in[15:0]), .offset(offset[13:0]),
    .reg_target(reg_target[15:0]),
    .flag_we(flag_we), .sign_in(sign_in), .carry_in(carry_in), .zero_in(zero_in),
    .taken(b_taken), .next_pc(b_next_pc), .pc_valid(b_pc_valid),
    .link_we(b_link_we), .link_addr(b_link_addr), .flush(b_flush)
  );

  branch_resolve_unit #(.FLUSH_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready(c_ready), .jtype(jtype),
    .link(link), .pc_in(pc_in), .offset(offset), .reg_target(reg_target),
    .flag_we(flag_we), .sign_in(sign_in), .carry_in(carry_in), .zero_in(zero_in),
    .taken(c_taken), .next_pc(c_next_pc), .pc_valid(c_pc_valid),
    .link_we(c_link_we), .link_addr(c_link_addr), .flush(c_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one branch for a single cycle, then drop valid and the flag strobe.
  task automatic issue(input logic [2:0] jt, input logic [31:0] pc, input int off,
                       input logic lk);
    valid_in = 1'b1;
    jtype    = jt;
    pc_in    = pc;
    offset   = 26'(off);
    link     = lk;
    tick();
    valid_in = 1'b0;
    flag_we  = 1'b0;
    link     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; jtype = 3'd0; link = 1'b0;
    pc_in = 32'h0; offset = 26'h0; reg_target = 32'h0;
    flag_we = 1'b0; sign_in = 1'b0; carry_in = 1'b0; zero_in = 1'b0;

    tick(); tick();
    chkb("rst_ready", a_ready, 1'b1);
    chkb("rst_flush", a_flush, 1'b0);
    chkb("rst_pc_valid", a_pc_valid, 1'b0);
    chk ("rst_next_pc", a_next_pc, 32'h0);
    rst = 1'b0;

    // bltz with bypassed sign flag
    flag_we = 1'b1; sign_in = 1'b1;
    issue(3'd3, 32'h100, 3, 1'b0);
    chkb("bltz_taken", a_taken, 1'b1);
    chkb("bltz_pc_valid", a_pc_valid, 1'b1);
    chk ("bltz_next_pc", a_next_pc, 32'h110);
    chkb("bltz_flush1", a_flush, 1'b1);
    chkb("bltz_ready1", a_ready, 1'b0);
    tick();
    chkb("bltz_taken_pulse", a_taken, 1'b0);
    chkb("bltz_flush2", a_flush, 1'b1);
    chkb("bltz_ready2", a_ready, 1'b0);
    tick();
    chkb("bltz_flush_end", a_flush, 1'b0);
    chkb("bltz_ready_end", a_ready, 1'b1);

    // bnz against registered zf=1
    flag_we = 1'b1; sign_in = 1'b0; carry_in = 1'b0; zero_in = 1'b1;
    tick();
    flag_we = 1'b0;
    issue(3'd5, 32'h200, 0, 1'b0);
    chkb("bnz_taken", a_taken, 1'b0);
    chkb("bnz_pc_valid", a_pc_valid, 1'b1);
    chk ("bnz_next_pc", a_next_pc, 32'h204);
    chkb("bnz_ready", a_ready, 1'b1);
    chkb("bnz_flush", a_flush, 1'b0);

    issue(3'd0, 32'h500, 5, 1'b0);
    chkb("none_pc_valid", a_pc_valid, 1'b1);
    chkb("none_taken", a_taken, 1'b0);
    chk ("none_next_pc", a_next_pc, 32'h504);

    // b with link, negative offset; valid during flush is ignored
    issue(3'd1, 32'h40, -4, 1'b1);
    chkb("bl_taken", a_taken, 1'b1);
    chk ("bl_next_pc", a_next_pc, 32'h34);
    chkb("bl_link_we", a_link_we, 1'b1);
    chk ("bl_link_addr", a_link_addr, 32'h44);
    valid_in = 1'b1; jtype = 3'd1; pc_in = 32'h800;
    tick();
    valid_in = 1'b0;
    chkb("flush_ignore_pc_valid", a_pc_valid, 1'b0);
    chk ("flush_ignore_next_pc", a_next_pc, 32'h34);
    chk ("flush_hold_link_addr", a_link_addr, 32'h44);
    tick();
    chkb("bl_ready_back", a_ready, 1'b1);
    chkb("bl_link_we_pulse", a_link_we, 1'b0);

    // br to register, then reset in the second flush cycle
    reg_target = 32'hDEADBEE0;
    issue(3'd2, 32'h1234, 0, 1'b0);
    chk ("br_next_pc", a_next_pc, 32'hDEADBEE0);
    chkb("br_taken", a_taken, 1'b1);
    tick();
    chkb("br_flush2", a_flush, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkb("midrst_flush", a_flush, 1'b0);
    chkb("midrst_ready", a_ready, 1'b1);
    chkb("midrst_taken", a_taken, 1'b0);
    chkb("midrst_pc_valid", a_pc_valid, 1'b0);
    chkb("midrst_link_we", a_link_we, 1'b0);
    chk ("midrst_next_pc", a_next_pc, 32'h0);
    chk ("midrst_link_addr", a_link_addr, 32'h0);
    issue(3'd5, 32'h900, 0, 1'b0);
    chkb("midrst_zf_cleared", a_taken, 1'b1);
    chk ("midrst_bnz_next_pc", a_next_pc, 32'h904);
    tick(); tick();

    // 16-bit PC wraps
    rst = 1'b1; tick(); rst = 1'b0;
    issue(3'd1, 32'h0000FFFC, 1, 1'b0);
    chkb("wrap16_taken", b_taken, 1'b1);
    chk ("wrap16_next_pc", {16'h0, b_next_pc}, 32'h0004);
    chk ("nowrap32_next_pc", a_next_pc, 32'h00010004);
    tick(); tick();

    // zero flush cycles: back-to-back taken bcy
    rst = 1'b1; tick(); rst = 1'b0;
    flag_we = 1'b1; carry_in = 1'b1; zero_in = 1'b0; sign_in = 1'b0;
    tick();
    flag_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(3'd6, 32'h1000 + 32'(4 * i), 1, 1'b0);
      chkb($sformatf("bcy%0d_taken", i), c_taken, 1'b1);
      chkb($sformatf("bcy%0d_pc_valid", i), c_pc_valid, 1'b1);
      chkb($sformatf("bcy%0d_flush", i), c_flush, 1'b0);
      chkb($sformatf("bcy%0d_ready", i), c_ready, 1'b1);
      chk ($sformatf("bcy%0d_next_pc", i), c_next_pc, 32'h1008 + 32'(4 * i));
    end
    issue(3'd7, 32'h2000, 0, 1'b0);
    chkb("bncy_taken", c_taken, 1'b0);
    chk ("bncy_next_pc", c_next_pc, 32'h2004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
